// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, write-source and
// PC-select codes, FSM states and the decoded-instruction record.
package cu_pkg;

    localparam logic [3:0] OP_MOV  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;
    localparam logic [3:0] OP_JAL  = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_LI   = 4'hF;

    localparam logic [1:0] SEL_W_ALU  = 2'd0;
    localparam logic [1:0] SEL_W_MEM  = 2'd1;
    localparam logic [1:0] SEL_W_LINK = 2'd2;
    localparam logic [1:0] SEL_W_IMM  = 2'd3;

    localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd1;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WA_NONE = 2'd0,
        WA_RT   = 2'd1,
        WA_ZERO = 2'd2,
        WA_ONES = 2'd3
    } wr_addr_kind_t;

    typedef struct packed {
        logic          writes_reg;
        wr_addr_kind_t wr_addr_kind;
        logic [1:0]    sel_w_source;
        logic          is_mem;
        logic          is_load;
        logic          is_jump;
        logic          is_branch;
    } decode_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: classifies an opcode into register-write,
// write-source, memory and control-flow attributes.
module cu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_MOV, OP_NOT, OP_SLL, OP_SRL, OP_ADDI: begin
                dec.writes_reg   = 1'b1;
                dec.wr_addr_kind = WA_RT;
                dec.sel_w_source = SEL_W_ALU;
            end
            OP_ADD, OP_AND, OP_NOR, OP_SLT: begin
                dec.writes_reg   = 1'b1;
                dec.wr_addr_kind = WA_ZERO;
                dec.sel_w_source = SEL_W_ALU;
            end
            OP_J: begin
                dec.is_jump = 1'b1;
            end
            OP_JAL: begin
                dec.is_jump      = 1'b1;
                dec.writes_reg   = 1'b1;
                dec.wr_addr_kind = WA_ONES;
                dec.sel_w_source = SEL_W_LINK;
            end
            OP_LW: begin
                dec.is_mem       = 1'b1;
                dec.is_load      = 1'b1;
                dec.writes_reg   = 1'b1;
                dec.wr_addr_kind = WA_RT;
                dec.sel_w_source = SEL_W_MEM;
            end
            OP_SW: begin
                dec.is_mem = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.is_branch = 1'b1;
            end
            OP_LI: begin
                dec.writes_reg   = 1'b1;
                dec.wr_addr_kind = WA_RT;
                dec.sel_w_source = SEL_W_IMM;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: fetches over valid/ready, then walks DECODE/EXEC or
// DECODE/MEM(/WB), driving register-file, memory and PC control strobes.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned INSTR_W    = 8,
    parameter int unsigned REG_ADDR_W = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    input  logic                  zero_flag,
    input  logic                  mem_ready,
    output logic [3:0]            alu_op,
    output logic [REG_ADDR_W-1:0] reg_addr_0,
    output logic [REG_ADDR_W-1:0] reg_addr_1,
    output logic [REG_ADDR_W-1:0] reg_addr_w,
    output logic                  reg_w_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic [1:0]            sel_w_source,
    output logic [1:0]            pc_sel,
    output logic                  pc_w_en,
    output logic                  busy,
    output logic [CNT_W-1:0]      retire_count
);

    state_t               state;
    logic [INSTR_W-1:0]   instr_reg;
    logic [CNT_W-1:0]     retire_cnt;
    logic [3:0]           opcode;
    logic [REG_ADDR_W-1:0] rs, rt;
    decode_t              dec;

    assign opcode = instr_reg[INSTR_W-1 -: 4];
    assign rs     = instr_reg[REG_ADDR_W-1:0];
    assign rt     = instr_reg[2*REG_ADDR_W-1 -: REG_ADDR_W];

    cu_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            instr_reg  <= '0;
            retire_cnt <= '0;
        end else begin
            if (pc_w_en)
                retire_cnt <= retire_cnt + CNT_W'(1);
            unique case (state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        instr_reg <= instr;
                        state     <= ST_DECODE;
                    end
                end
                ST_DECODE: state <= dec.is_mem ? ST_MEM : ST_EXEC;
                ST_EXEC:   state <= ST_FETCH;
                ST_MEM: begin
                    if (mem_ready)
                        state <= dec.is_load ? ST_WB : ST_FETCH;
                end
                ST_WB:     state <= ST_FETCH;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Branch resolution and store retirement depend on same-cycle zero_flag and
    // mem_ready, so strobes decode from the registered state rather than being
    // registered one cycle early. Reset masks everything immediately.
    always_comb begin
        instr_ready  = 1'b0;
        busy         = 1'b0;
        alu_op       = '0;
        reg_addr_0   = '0;
        reg_addr_1   = '0;
        reg_addr_w   = '0;
        reg_w_en     = 1'b0;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        sel_w_source = SEL_W_ALU;
        pc_sel       = PC_SEL_NEXT;
        pc_w_en      = 1'b0;
        retire_count = '0;
        if (!reset) begin
            retire_count = retire_cnt;
            instr_ready  = (state == ST_FETCH);
            busy         = (state != ST_FETCH);
            if (state != ST_FETCH) begin
                reg_addr_0   = rs;
                reg_addr_1   = rt;
                sel_w_source = dec.sel_w_source;
                case (dec.wr_addr_kind)
                    WA_RT:   reg_addr_w = rt;
                    WA_ONES: reg_addr_w = '1;
                    default: reg_addr_w = '0;
                endcase
            end
            unique case (state)
                ST_EXEC: begin
                    alu_op   = opcode;
                    pc_w_en  = 1'b1;
                    reg_w_en = dec.writes_reg;
                    if (dec.is_jump)
                        pc_sel = PC_SEL_JUMP;
                    else if (dec.is_branch && (zero_flag ^ (opcode == OP_BNE)))
                        pc_sel = PC_SEL_BRANCH;
                end
                ST_MEM: begin
                    alu_op   = opcode;
                    mem_r_en = dec.is_load;
                    mem_w_en = !dec.is_load;
                    pc_w_en  = !dec.is_load && mem_ready;
                end
                ST_WB: begin
                    reg_w_en = 1'b1;
                    pc_w_en  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
